// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, tx state encoding and divider helper
package uart_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Clock cycles per bit; shared with the receiver so both ends agree on timing.
  function automatic int calc_cnt_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter emitting a one-cycle tick on wrap
module uart_baud_tick #(
  parameter int CNT_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CNT_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick is purely a function of the count so clear (which depends on tick) cannot loop back.
  assign tick = (cnt_q == LAST);

  // Next count: forced to zero by clear, otherwise counts 0..CNT_DIV-1 and wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with one-entry holding register
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  ready,
  output logic                  TxD,
  output logic                  busy
);

  localparam int CNT_DIV = calc_cnt_div(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic                  txd_q, txd_d;

  logic tick;
  logic clear;
  logic accept;
  logic direct;
  logic drain;
  logic load;

  assign ready  = !hold_full_q;
  assign accept = data_valid && !hold_full_q;
  assign busy   = (state_q != ST_IDLE) || hold_full_q;
  assign TxD    = txd_q;

  // Counter is parked at zero while idle and restarted on every frame load.
  assign clear = load || (state_q == ST_IDLE);

  uart_baud_tick #(
    .CNT_DIV(CNT_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  // Frame sequencing, hold-register bookkeeping and the next line level.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;
    direct      = 1'b0;
    drain       = 1'b0;
    txd_d       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          drain = 1'b1;
        end else if (accept) begin
          direct = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d   = ST_STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (hold_full_q) begin
            drain = 1'b1;
          end else if (accept) begin
            direct = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    load = direct || drain;

    // A byte taken while the shifter is free skips the hold register entirely.
    if (load) begin
      state_d   = ST_START;
      shift_d   = drain ? hold_q : data;
      bit_idx_d = 3'd0;
    end

    if (drain) begin
      hold_full_d = 1'b0;
    end

    if (accept && !direct) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    // Line level follows the state being entered so TxD is a clean register output.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[bit_idx_d];
      default:  txd_d = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= 3'd0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      txd_q       <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;

  localparam int CLK_FREQ  = 96_000;
  localparam int BAUD_RATE = 9600;
  localparam int FRAME_CYC = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       ready;
  logic       TxD;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_err = 0;

  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] b;
    logic [9:0] line;
  } vec_t;

  vec_t vecs[6];

  uart_transmitter #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .data_valid(data_valid),
    .ready     (ready),
    .TxD       (TxD),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic [9:0] f;
    f[9] = 1'b0;
    for (int i = 0; i < 8; i++) f[8-i] = b[i];
    f[0] = 1'b1;
    return f;
  endfunction

  // Reference receiver: detects the start edge, samples mid-bit, checks the stop bit.
  int         rx_c = 0;
  logic       rx_act = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (TxD === 1'b0) begin
          rx_act = 1'b1;
          rx_c   = 0;
        end
      end else begin
        rx_c++;
        if (rx_c == 4 && TxD !== 1'b0) begin
          rx_act = 1'b0;
        end else if (rx_c >= 14 && rx_c <= 84 && (rx_c - 14) % 10 == 0) begin
          rx_sh[(rx_c-14)/10] = TxD;
        end else if (rx_c == 94) begin
          if (TxD === 1'b1) rx_q.push_back(rx_sh);
          else frame_err++;
          rx_act = 1'b0;
        end
      end
    end
  end

  // Offers n bytes with data_valid held high, checking TxD and busy on every cycle
  // from the first accepting edge until n back-to-back frames have been sent.
  task automatic run_stream(input string name, input logic [7:0] b[4],
                            input logic [9:0] pat[4], input int n, output int acc[4]);
    int   idx;
    int   k;
    int   guard;
    logic rdy;
    idx   = 0;
    k     = -1;
    guard = 0;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    rx_q.delete();
    data       = b[0];
    data_valid = 1'b1;
    while (k < n * FRAME_CYC && guard < n * FRAME_CYC + 200) begin
      if (k >= 0) begin
        check($sformatf("%s txd k=%0d", name, k), {31'd0, TxD},
              {31'd0, pat[k/FRAME_CYC][9-((k%FRAME_CYC)/10)]});
        check($sformatf("%s busy k=%0d", name, k), {31'd0, busy}, 32'd1);
      end
      rdy = ready;
      @(negedge clk);
      guard++;
      if (rdy && data_valid) begin
        acc[idx] = cyc;
        idx++;
        if (idx < n) begin
          data = b[idx];
        end else begin
          data_valid = 1'b0;
          data       = ~data;
        end
      end
      if (k >= 0) k++;
      else if (idx > 0) k = 0;
    end
    check({name, " completed in budget"}, {31'd0, (k == n * FRAME_CYC)}, 32'd1);
    check({name, " accepted all"}, idx, n);
    check({name, " idle txd"}, {31'd0, TxD}, 32'd1);
    check({name, " idle busy"}, {31'd0, busy}, 32'd0);
    check({name, " rx count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check($sformatf("%s rx byte %0d", name, i), {24'd0, rx_q[i]}, {24'd0, b[i]});
    data_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] bb[4];
    logic [9:0] pp[4];
    int         acc[4];
    logic       ok;

    vecs[0] = '{8'hA5, 10'b0_10100101_1};
    vecs[1] = '{8'h00, 10'b0_00000000_1};
    vecs[2] = '{8'hFF, 10'b0_11111111_1};
    vecs[3] = '{8'h3C, 10'b0_00111100_1};
    vecs[4] = '{8'h01, 10'b0_10000000_1};
    vecs[5] = '{8'h5A, 10'b0_01011010_1};

    // Reset and idle line.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset txd", {31'd0, TxD}, 32'd1);
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (TxD !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("idle 50 cycles", {31'd0, ok}, 32'd1);

    // Single frames from idle against hand-computed line patterns.
    foreach (vecs[i]) begin
      bb    = '{8'h00, 8'h00, 8'h00, 8'h00};
      pp    = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
      bb[0] = vecs[i].b;
      pp[0] = vecs[i].line;
      run_stream($sformatf("single %02h", vecs[i].b), bb, pp, 1, acc);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: second byte goes to hold on the next edge, no gap between frames.
    bb = '{8'h00, 8'hFF, 8'h00, 8'h00};
    foreach (bb[i]) pp[i] = frame_of(bb[i]);
    run_stream("b2b", bb, pp, 2, acc);
    check("b2b second accept", acc[1] - acc[0], 1);

    // Third byte waits for the drain edge and is taken on the edge after it.
    bb = '{8'h12, 8'h34, 8'h56, 8'h00};
    foreach (bb[i]) pp[i] = frame_of(bb[i]);
    run_stream("three", bb, pp, 3, acc);
    check("three second accept", acc[1] - acc[0], 1);
    check("three third accept", acc[2] - acc[0], FRAME_CYC + 1);

    // Loopback of four bytes at peak rate.
    bb = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    foreach (bb[i]) pp[i] = frame_of(bb[i]);
    run_stream("loop", bb, pp, 4, acc);
    check("loop fourth accept", acc[3] - acc[2], FRAME_CYC);

    // Reset in the middle of DATA with a byte held.
    rx_q.delete();
    data       = 8'h3C;
    data_valid = 1'b1;
    @(negedge clk);
    check("rst-mid first ready", {31'd0, ready}, 32'd1);
    data = 8'h99;
    @(negedge clk);
    data_valid = 1'b0;
    check("rst-mid hold full", {31'd0, ready}, 32'd0);
    repeat (74) @(negedge clk);
    check("rst-mid bit6 low", {31'd0, TxD}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst-mid txd", {31'd0, TxD}, 32'd1);
    check("rst-mid ready", {31'd0, ready}, 32'd1);
    check("rst-mid busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("rst-mid no resume", {31'd0, ok}, 32'd1);
    check("rst-mid rx empty", rx_q.size(), 0);

    check("frame errors", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
